// File: rtl/rv_pkg.sv
// rv_pkg: shared constants and checksum function for the 16-bit ready/valid stream stages.
package rv_pkg;
  localparam int DW = 16;
  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam logic [15:0] DEF_LIMIT = 16'h2000;
  function automatic logic [DW-1:0] csum_next(input logic [DW-1:0] c, input logic [DW-1:0] d);
    return {c[DW-2:0], c[DW-1]} ^ d;
  endfunction
endpackage

// File: rtl/rv_sink_checker_if.sv
// rv_sink_checker_if: 16-bit ready/valid stream bundle.
interface rv_sink_checker_if;
  import rv_pkg::*;
  logic [DW-1:0] data;
  logic valid;
  logic ready;
  modport master (output data, output valid, input ready);
  modport slave (input data, input valid, output ready);
endinterface

// File: rtl/rv_lfsr16.sv
// rv_lfsr16: free-running 16-bit Galois LFSR, restarts from the seed on reset.
module rv_lfsr16 import rv_pkg::*; #(
  parameter logic [31:0] SEED = 32'h00005678
) (
  input  logic        clock,
  input  logic        reset,
  output logic [15:0] state
);
  localparam logic [15:0] INIT = (SEED[15:0] == 16'd0) ? 16'd1 : SEED[15:0];
  logic [15:0] state_q, state_d;
  always_comb state_d = state_q[0] ? ((state_q >> 1) ^ LFSR_MASK) : (state_q >> 1);
  always_ff @(posedge clock) state_q <= reset ? INIT : state_d;
  assign state = state_q;
endmodule

// File: rtl/rv_sink_checker.sv
// rv_sink_checker: stream sink with LFSR backpressure, protocol/range checks, count and checksum.
module rv_sink_checker import rv_pkg::*; #(
  parameter logic [31:0] SEED         = 32'h00005678,
  parameter logic [4:0]  STALL_THRESH = 5'd4,
  parameter logic [15:0] LIMIT        = DEF_LIMIT
) (
  input  logic               clock,
  input  logic               reset,
  rv_sink_checker_if.slave   in_if,
  output logic [15:0]        count,
  output logic [15:0]        checksum,
  output logic               err_range,
  output logic               err_drop,
  output logic               err_change,
  output logic [15:0]        err_index
);
  logic [15:0] lfsr;
  logic        unused_lfsr;
  logic        xfer, stall, drop, change, range;
  logic [15:0] count_q, count_d, checksum_q, checksum_d, held_data_q, held_data_d, err_index_d, err_index_q;
  logic        held_valid_q, held_valid_d;
  logic        err_range_q, err_range_d, err_drop_q, err_drop_d, err_change_q, err_change_d;
  rv_lfsr16 #(.SEED(SEED)) u_lfsr (.clock(clock), .reset(reset), .state(lfsr));
  assign unused_lfsr = ^lfsr[15:4];
  // ready depends only on registered LFSR state, never on valid
  assign in_if.ready = !reset && ({1'b0, lfsr[3:0]} >= STALL_THRESH);
  always_comb begin
    xfer         = in_if.valid && in_if.ready;
    stall        = in_if.valid && !in_if.ready;
    drop         = held_valid_q && !in_if.valid;
    change       = held_valid_q && in_if.valid && (in_if.data != held_data_q);
    range        = xfer && (in_if.data >= LIMIT);
    count_d      = count_q + {15'd0, xfer};
    checksum_d   = xfer ? csum_next(checksum_q, in_if.data) : checksum_q;
    held_valid_d = stall;
    held_data_d  = stall ? in_if.data : held_data_q;
    err_range_d  = err_range_q | range;
    err_drop_d   = err_drop_q | drop;
    err_change_d = err_change_q | change;
    err_index_d  = ((drop | change | range) && !(err_range_q | err_drop_q | err_change_q)) ? count_q : err_index_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q      <= '0;
      checksum_q   <= '0;
      held_valid_q <= 1'b0;
      held_data_q  <= '0;
      err_range_q  <= 1'b0;
      err_drop_q   <= 1'b0;
      err_change_q <= 1'b0;
      err_index_q  <= '0;
    end else begin
      count_q      <= count_d;
      checksum_q   <= checksum_d;
      held_valid_q <= held_valid_d;
      held_data_q  <= held_data_d;
      err_range_q  <= err_range_d;
      err_drop_q   <= err_drop_d;
      err_change_q <= err_change_d;
      err_index_q  <= err_index_d;
    end
  end
  assign count      = count_q;
  assign checksum   = checksum_q;
  assign err_range  = err_range_q;
  assign err_drop   = err_drop_q;
  assign err_change = err_change_q;
  assign err_index  = err_index_q;
endmodule
